// File: rtl/bram_arbiter.sv
// bram_arbiter: two-master / one-slave arbiter in front of the shared bram.
// Master 0 is the CPU and master 1 is an auxiliary bus master. Both speak the
// FemtoRV32 memory protocol. A request that is not contested is granted in its
// strobe cycle, so it adds zero wait states. A request that loses contention is
// parked for one cycle and reported through the master's busy outputs.
// Optional macro ARB_FIXED_PRIO_EN: when defined, master 0 always wins
// contention and the round-robin pointer is removed.
module bram_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int RR_INIT = 0
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [31:0]       m0_wdata,
   input  logic [3:0]        m0_wmask,
   input  logic              m0_rstrb,
   output logic [31:0]       m0_rdata,
   output logic              m0_rbusy,
   output logic              m0_wbusy,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [31:0]       m1_wdata,
   input  logic [3:0]        m1_wmask,
   input  logic              m1_rstrb,
   output logic [31:0]       m1_rdata,
   output logic              m1_rbusy,
   output logic              m1_wbusy,
   output logic [ADDR_W-1:0] s_addr,
   output logic [31:0]       s_wdata,
   output logic [3:0]        s_wmask,
   output logic              s_rstrb,
   input  logic [31:0]       s_rdata
);

   typedef enum logic [1:0] {RET_NONE, RET_M0, RET_M1} ret_e;

   // Both masters are gathered into arrays so that per-master logic is written once.
   logic [ADDR_W-1:0] req_addr [2];
   logic [31:0]       req_wdata [2];
   logic [3:0]        req_wmask [2];
   logic [1:0]        req_strb;

   logic [1:0]        live, cand, gnt, cand_rd;
   logic [ADDR_W-1:0] cand_addr [2];
   logic [31:0]       cand_wdata [2];
   logic [3:0]        cand_wmask [2];

   logic              pend_q [2];
   logic [ADDR_W-1:0] pend_addr_q [2];
   logic [31:0]       pend_wdata_q [2];
   logic [3:0]        pend_wmask_q [2];
   logic              pend_rd_q [2];
   logic [31:0]       hold_q [2];

   logic [ADDR_W-1:0] last_addr_q;
   logic [31:0]       last_wdata_q;
   ret_e              ret_q, ret_d;
   logic              any_gnt, sel;

   assign req_addr[0]  = m0_addr;
   assign req_addr[1]  = m1_addr;
   assign req_wdata[0] = m0_wdata;
   assign req_wdata[1] = m1_wdata;
   assign req_wmask[0] = m0_wmask;
   assign req_wmask[1] = m1_wmask;
   assign req_strb     = {m1_rstrb, m0_rstrb};

   // Candidate per master: a parked request always shadows the live port.
   // Live requests are masked while reset is held, so the slave strobes drop at once.
   for (genvar gi = 0; gi < 2; gi++) begin : g_cand
      assign live[gi]       = resetn & (req_strb[gi] | (|req_wmask[gi]));
      assign cand[gi]       = pend_q[gi] | live[gi];
      assign cand_addr[gi]  = pend_q[gi] ? pend_addr_q[gi]  : req_addr[gi];
      assign cand_wdata[gi] = pend_q[gi] ? pend_wdata_q[gi] : req_wdata[gi];
      assign cand_wmask[gi] = pend_q[gi] ? pend_wmask_q[gi] : req_wmask[gi];
      // A strobe that arrives together with a write mask is treated as a write.
      assign cand_rd[gi]    = pend_q[gi] ? pend_rd_q[gi]    : ~(|req_wmask[gi]);
   end

`ifdef ARB_FIXED_PRIO_EN
   assign gnt[0] = cand[0];
   assign gnt[1] = cand[1] & ~cand[0];
`else
   logic rr_q, rr_d;

   assign gnt[0] = cand[0] & (~cand[1] | ~rr_q);
   assign gnt[1] = cand[1] & (~cand[0] |  rr_q);

   // The pointer moves only on contention, and it moves to the master that lost.
   always_comb begin
      rr_d = rr_q;
      if (cand[0] && cand[1]) rr_d = ~rr_q;
   end

   // Round-robin pointer register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) rr_q <= (RR_INIT != 0);
      else         rr_q <= rr_d;
   end
`endif

   assign any_gnt = |gnt;
   assign sel     = gnt[1];

   // Slave port is a combinational mux on the granted candidate; the address and
   // data hold their last granted values while the port is idle.
   always_comb begin
      s_addr  = last_addr_q;
      s_wdata = last_wdata_q;
      s_wmask = 4'b0000;
      s_rstrb = 1'b0;
      ret_d   = RET_NONE;
      if (any_gnt) begin
         s_addr  = cand_addr[sel];
         s_wdata = cand_wdata[sel];
         if (cand_rd[sel]) begin
            s_rstrb = 1'b1;
            ret_d   = sel ? RET_M1 : RET_M0;
         end else begin
            s_wmask = cand_wmask[sel];
         end
      end
   end

   // Park losing live requests, retire parked ones when granted, route read returns.
   // A new request from a master that is already parked is dropped.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int k = 0; k < 2; k++) begin
            pend_q[k]       <= 1'b0;
            pend_addr_q[k]  <= '0;
            pend_wdata_q[k] <= '0;
            pend_wmask_q[k] <= '0;
            pend_rd_q[k]    <= 1'b0;
            hold_q[k]       <= '0;
         end
         last_addr_q  <= '0;
         last_wdata_q <= '0;
         ret_q        <= RET_NONE;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (pend_q[k]) begin
               if (gnt[k]) pend_q[k] <= 1'b0;
            end else if (live[k] && !gnt[k]) begin
               pend_q[k]       <= 1'b1;
               pend_addr_q[k]  <= req_addr[k];
               pend_wdata_q[k] <= req_wdata[k];
               pend_wmask_q[k] <= req_wmask[k];
               pend_rd_q[k]    <= ~(|req_wmask[k]);
            end
         end
         if (ret_q == RET_M0) hold_q[0] <= s_rdata;
         if (ret_q == RET_M1) hold_q[1] <= s_rdata;
         if (any_gnt) begin
            last_addr_q  <= s_addr;
            last_wdata_q <= s_wdata;
         end
         ret_q <= ret_d;
      end
   end

   assign m0_rdata = (ret_q == RET_M0) ? s_rdata : hold_q[0];
   assign m1_rdata = (ret_q == RET_M1) ? s_rdata : hold_q[1];
   assign m0_rbusy = pend_q[0] &  pend_rd_q[0];
   assign m0_wbusy = pend_q[0] & ~pend_rd_q[0];
   assign m1_rbusy = pend_q[1] &  pend_rd_q[1];
   assign m1_wbusy = pend_q[1] & ~pend_rd_q[1];

endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Two-master, one-slave arbiter that shares the program/data `bram` between the FemtoRV32 CPU (master 0) and an auxiliary bus master (master 1, e.g. a DMA or debug loader).
- Both master ports use the FemtoRV32 memory protocol. The CPU is slowed only when the two masters contend, through its `mem_rbusy`/`mem_wbusy` inputs, which are currently tied to 0.
- Sits between the CPU/aux master and the `cs[0]`-gated `bram` port in the SoC.

Parameters:
- ADDR_W, 32: width of all address ports.
- RR_INIT, 0: master that holds round-robin priority after reset (0 or 1).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- m0_addr  in  ADDR_W  CPU address
- m0_wdata  in  32  CPU write data
- m0_wmask  in  4  CPU byte write enables; any bit set = write request
- m0_rstrb  in  1  CPU read strobe, single-cycle pulse
- m0_rdata  out  32  CPU read data
- m0_rbusy  out  1  CPU read pending
- m0_wbusy  out  1  CPU write pending
- m1_addr, m1_wdata, m1_wmask, m1_rstrb, m1_rdata, m1_rbusy, m1_wbusy: same as m0_*, for the auxiliary master
- s_addr  out  ADDR_W  to `bram`
- s_wdata  out  32  to `bram`
- s_wmask  out  4  to `bram`
- s_rstrb  out  1  to `bram`
- s_rdata  in  32  from `bram`; valid the cycle after `s_rstrb`

Behaviour:
- Request: a master raises `rstrb` or a nonzero `wmask` for one cycle, with addr/wdata valid in that cycle.
  - A new request from a master that already has one pending is ignored; this is a protocol violation (see Test Plan assertion).
  - `rstrb` together with a nonzero `wmask` is treated as a write.
- Candidates each cycle, per master: its latched pending request if one exists, else its live request.
- Grant: exactly one candidate is granted per cycle, combinationally. The slave port is driven from the granted source in that same cycle.
  - With no grant: `s_rstrb`=0, `s_wmask`=0, and `s_addr`/`s_wdata` hold the last granted values.
- Arbitration:
  - Single candidate: it wins.
  - Both candidates: the master named by the priority pointer `rr` wins, then `rr` flips to the other master.
  - `rr` changes only on contention.
- Loser / pending capture: a live request that is not granted is latched into `pendK` (addr, wdata, wmask, is_rd) at the clock edge. `pendK` clears on the edge of the cycle in which it is granted.
  - A pending request always beats a new request from the same master; the new request cannot exist, since it would be a protocol violation.
- Busy outputs, registered: `mK_rbusy` = `pendK` & `is_rd`; `mK_wbusy` = `pendK` & ~`is_rd`.
  - An uncontested request is granted in its strobe cycle, so busy stays 0 and the access has zero wait states, identical to a direct connection.
- Read return:
  - A register `ret_owner` (none/0/1) records which master's read was issued.
  - In the following cycle, `mK_rdata` = `s_rdata` for that owner, and `s_rdata` is also captured into `holdK`.
  - Otherwise `mK_rdata` = `holdK`, so each master keeps its last read data.
- Latency:
  - Uncontested read: data valid 1 cycle after the strobe.
  - Contested loser: data valid 2 cycles after the strobe, with busy high for exactly 1 cycle.
  - Writes complete in the grant cycle.
- Throughput: one access per cycle. Back-to-back alternating requests never starve a master; the maximum wait is 1 cycle.
- Reset (async, any time, including mid-access): `pend0`/`pend1`=0, `ret_owner`=none, `rr`=RR_INIT, `hold0`/`hold1`=0, all busy=0, `s_rstrb`=0, `s_wmask`=0, `s_addr`=0, `s_wdata`=0. An in-flight read is dropped.

Optional Feature:
- ARB_FIXED_PRIO_EN
  - Defined: master 0 (CPU) always wins contention, and `rr` is unused/removed. Master 1 may wait indefinitely while the CPU issues a request every cycle.
  - Undefined: round-robin as specified above.

Test Plan:
- Uncontested read: m0 reads 0x0000_0010 (`bram`=0xDEADBEEF) -> `s_rstrb` same cycle, `m0_rdata`=0xDEADBEEF next cycle, `m0_rbusy` never 1.
- Simultaneous reads, `rr`=0: m0 reads 0x10 (0x11111111), m1 reads 0x20 (0x22222222) -> m0 data at T+1; `m1_rbusy`=1 at T+1; m1 granted at T+1; `m1_rdata`=0x22222222 at T+2; `rr`=1 afterwards.
- Write vs read collision with `rr`=1: m0 writes 0x0000_00AA (`wmask`=0001) to 0x30, m1 reads 0x30 -> m1 served first and returns the old value; `m0_wbusy`=1 for 1 cycle; a subsequent m0 read of 0x30 returns 0x..AA.
- Hold: after m0 reads 0xDEADBEEF, m1 performs 3 reads -> `m0_rdata` stays 0xDEADBEEF throughout.
- Reset mid-contention: assert `resetn`=0 while `m1_rbusy`=1 -> all busy=0, `s_rstrb`=0 and `s_wmask`=0 immediately, `rr`=RR_INIT after release; with ARB_FIXED_PRIO_EN, repeated simultaneous requests always grant m0.
- Assertion: a new request while `pendK`=1 is flagged, and `pendK` contents are unchanged.
